// File: rtl/cpu_mc_pkg.sv
// Shared FSM state encoding and Hack C-instruction field positions for cpu_mc.
package cpu_mc_pkg;

  typedef enum logic [2:0] {FETCH, READ, EXEC, WRITE, HALT} state_t;

  localparam int unsigned BIT_A = 12;
  localparam int unsigned C_HI  = 11;
  localparam int unsigned C_LO  = 6;
  localparam int unsigned D_HI  = 5;
  localparam int unsigned D_LO  = 3;
  localparam int unsigned J_HI  = 2;
  localparam int unsigned J_LO  = 0;

  localparam logic [2:0] JMP_ALWAYS = 3'b111;

endpackage

// File: rtl/cpu_mc_ctrl.sv
// cpu_mc sequencer: FSM, instruction decode, jump evaluation and self-jump halt detection.
module cpu_mc_ctrl
  import cpu_mc_pkg::*;
#(
  parameter int DW = 16,
  parameter int PW = 15
) (
  input  logic          clk50m,
  input  logic          rst,
  input  logic          en25m,
  input  logic [DW-1:0] instr,
  input  logic          instr_vld,
  input  logic          inM_vld,
  input  logic          wr_ack,
  input  logic          alu_zr,
  input  logic          alu_ng,
  input  logic [PW-1:0] a_tgt,
  input  logic [PW-1:0] pc,
  output logic [DW-1:0] a_imm,
  output logic [5:0]    alu_fn,
  output logic          sel_m,
  output logic          is_a,
  output logic          ld_a,
  output logic          ld_d,
  output logic          st_m,
  output logic          jmp,
  output logic          commit,
  output logic          mreg_ld,
  output logic          rd_req,
  output logic          writeM,
  output logic          halted
);

  state_t        state;
  logic [DW-1:0] ir;
  logic          halt_pend;
  logic          is_c;
  logic          need_rd;
  logic          self_jump;
  logic [2:0]    dst;
  logic [2:0]    jcond;

  always_comb begin
    is_c      = ir[DW-1];
    is_a      = ~is_c;
    dst       = ir[D_HI:D_LO];
    jcond     = ir[J_HI:J_LO];
    sel_m     = ir[BIT_A];
    alu_fn    = ir[C_HI:C_LO];
    a_imm     = {1'b0, ir[DW-2:0]};
    ld_a      = is_c & dst[2];
    ld_d      = is_c & dst[1];
    st_m      = is_c & dst[0];
    jmp       = is_c & ((jcond[2] & alu_ng) | (jcond[1] & alu_zr) |
                        (jcond[0] & ~alu_ng & ~alu_zr));
    self_jump = is_c && (jcond == JMP_ALWAYS) && (a_tgt == pc);
    need_rd   = instr[DW-1] & instr[BIT_A];
    commit    = en25m && (state == EXEC);
    mreg_ld   = en25m && (state == READ) && inM_vld;
  end

  // rd_req/writeM/halted are registered alongside the state so they track READ/WRITE/HALT exactly
  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      state     <= FETCH;
      ir        <= '0;
      halt_pend <= 1'b0;
      rd_req    <= 1'b0;
      writeM    <= 1'b0;
      halted    <= 1'b0;
    end else if (en25m) begin
      case (state)
        FETCH: begin
          if (instr_vld) begin
            ir <= instr;
            if (need_rd) begin
              state  <= READ;
              rd_req <= 1'b1;
            end else begin
              state <= EXEC;
            end
          end
        end
        READ: begin
          if (inM_vld) begin
            state  <= EXEC;
            rd_req <= 1'b0;
          end
        end
        EXEC: begin
          if (st_m) begin
            state     <= WRITE;
            writeM    <= 1'b1;
            halt_pend <= self_jump;
          end else if (self_jump) begin
            state  <= HALT;
            halted <= 1'b1;
          end else begin
            state <= FETCH;
          end
        end
        WRITE: begin
          if (wr_ack) begin
            writeM <= 1'b0;
            if (halt_pend) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              state <= FETCH;
            end
          end
        end
        HALT: state <= HALT;
        default: begin
          state  <= FETCH;
          rd_req <= 1'b0;
          writeM <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/cpu_mc.sv
// Multi-cycle Hack CPU with valid/ack fetch, read and write handshakes.
// Optional RETIRE_CNT_EN adds a 32-bit retired-instruction counter output.
module cpu_mc
  import cpu_mc_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 15,
  parameter int PW = 15
) (
  input  logic          clk50m,
  input  logic          rst,
  input  logic          en25m,
  input  logic [DW-1:0] instr,
  input  logic          instr_vld,
  input  logic [DW-1:0] inM,
  input  logic          inM_vld,
  input  logic          wr_ack,
  output logic          rd_req,
  output logic          writeM,
  output logic [DW-1:0] outM,
  output logic [AW-1:0] addressM,
  output logic [PW-1:0] pc,
  output logic          halted
`ifdef RETIRE_CNT_EN
  ,
  output logic [31:0]   retired
`endif
);

  logic [DW-1:0] a_reg;
  logic [DW-1:0] d_reg;
  logic [DW-1:0] mreg;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] a_imm;
  logic [5:0]    alu_fn;
  logic          sel_m;
  logic          is_a;
  logic          ld_a;
  logic          ld_d;
  logic          st_m;
  logic          jmp;
  logic          commit;
  logic          mreg_ld;
  logic [DW-1:0] alu_x;
  logic [DW-1:0] alu_y;
  logic [DW-1:0] alu_out;
  logic          alu_zr;
  logic          alu_ng;

  cpu_mc_ctrl #(
    .DW(DW),
    .PW(PW)
  ) u_ctrl (
    .clk50m   (clk50m),
    .rst      (rst),
    .en25m    (en25m),
    .instr    (instr),
    .instr_vld(instr_vld),
    .inM_vld  (inM_vld),
    .wr_ack   (wr_ack),
    .alu_zr   (alu_zr),
    .alu_ng   (alu_ng),
    .a_tgt    (a_reg[PW-1:0]),
    .pc       (pc),
    .a_imm    (a_imm),
    .alu_fn   (alu_fn),
    .sel_m    (sel_m),
    .is_a     (is_a),
    .ld_a     (ld_a),
    .ld_d     (ld_d),
    .st_m     (st_m),
    .jmp      (jmp),
    .commit   (commit),
    .mreg_ld  (mreg_ld),
    .rd_req   (rd_req),
    .writeM   (writeM),
    .halted   (halted)
  );

  // alu_fn = {zx, nx, zy, ny, f, no}
  always_comb begin
    alu_x = d_reg;
    alu_y = sel_m ? mreg : a_reg;
    if (alu_fn[5]) alu_x = '0;
    if (alu_fn[4]) alu_x = ~alu_x;
    if (alu_fn[3]) alu_y = '0;
    if (alu_fn[2]) alu_y = ~alu_y;
    alu_out = alu_fn[1] ? (alu_x + alu_y) : (alu_x & alu_y);
    if (alu_fn[0]) alu_out = ~alu_out;
    alu_zr = (alu_out == '0);
    alu_ng = alu_out[DW-1];
  end

  // writeM is high exactly in WRITE, so it selects the latched store address
  assign addressM = writeM ? addr_q : a_reg[AW-1:0];

  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      a_reg  <= '0;
      d_reg  <= '0;
      mreg   <= '0;
      addr_q <= '0;
      outM   <= '0;
      pc     <= '0;
    end else begin
      if (mreg_ld) mreg <= inM;
      if (commit) begin
        if (is_a)      a_reg <= a_imm;
        else if (ld_a) a_reg <= alu_out;
        if (ld_d) d_reg <= alu_out;
        if (st_m) begin
          addr_q <= a_reg[AW-1:0];
          outM   <= alu_out;
        end
        pc <= jmp ? a_reg[PW-1:0] : pc + PW'(1);
      end
    end
  end

`ifdef RETIRE_CNT_EN
  always_ff @(posedge clk50m or posedge rst) begin
    if (rst)         retired <= '0;
    else if (commit) retired <= retired + 32'd1;
  end
`endif

endmodule
